// File: rtl/demux14_pkg.sv
// Shared definitions for the registered 1:4 stream router: channel count,
// channel index type and the select-to-channel mapping.
package demux14_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef logic [CH_W-1:0] ch_idx_t;

  // Channel index is {s0, s1}: s0 is the MSB, so s0=1,s1=0 selects CH2.
  localparam ch_idx_t CH0 = 2'b00;
  localparam ch_idx_t CH1 = 2'b01;
  localparam ch_idx_t CH2 = 2'b10;
  localparam ch_idx_t CH3 = 2'b11;

  function automatic ch_idx_t sel_to_ch(input logic s0, input logic s1);
    return ch_idx_t'({s0, s1});
  endfunction

endpackage

// File: rtl/demux14_slot.sv
// One-entry holding register for a single output channel. Data reads 0
// whenever the slot is empty.
module demux14_slot
  import demux14_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // A load wins over a drain in the same cycle: the old word leaves and the
  // new one takes its place without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = valid_q ? data_q : '0;

endmodule

// File: rtl/demux14_stream_router.sv
// Registered, flow-controlled 1:4 demultiplexer. Each word is routed to one
// of four one-entry output slots, chosen by {s0,s1} or by a round-robin pointer.
module demux14_stream_router
  import demux14_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int RR_MODE = 0,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    s0,
  input  logic                    s1,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [1:0]              rr_ptr,
  output logic [CNT_W-1:0]        xfer_cnt
);

  // Handshakes: a transfer happens at a rising edge where valid && ready are
  // both 1. Valid never depends on ready; ready may depend on valid/select.

  ch_idx_t          rr_q;
  ch_idx_t          ch;
  logic             accept;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] slot_data [NUM_CH];

  assign ch = (RR_MODE != 0) ? rr_q : sel_to_ch(s0, s1);

  // Accept into an empty slot, or into a full one draining this same cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = !out_valid[ch] || out_ready[ch];
    end
  end

  assign accept = in_valid && in_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
    logic slot_load;
    logic slot_drain;

    assign slot_load  = accept && (ch == ch_idx_t'(c));
    assign slot_drain = out_valid[c] && out_ready[c];

    demux14_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (slot_load),
      .load_data(in_data),
      .drain    (slot_drain),
      .valid    (out_valid[c]),
      .data     (slot_data[c])
    );

    assign out_data[c*WIDTH +: WIDTH] = slot_data[c];
  end

  // Strict round-robin: the pointer only advances on an accept, so a blocked
  // channel stalls the input instead of being skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= CH0;
    end else if (accept && (RR_MODE != 0)) begin
      rr_q <= rr_q + ch_idx_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign rr_ptr   = (RR_MODE != 0) ? rr_q : 2'b00;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_demux14_stream_router.sv
// Directed bench for the 1:4 stream router: a select-mode instance and a
// round-robin instance with a 4-bit transfer counter.
module tb_demux14_stream_router;

  logic        clk;
  int          n_checks;
  int          n_errors;

  // Select-mode instance
  logic        rst0, in_valid0, s0_0, s1_0;
  logic        in_ready0;
  logic [7:0]  in_data0;
  logic [3:0]  out_valid0, out_ready0;
  logic [31:0] out_data0;
  logic [1:0]  rr_ptr0;
  logic [15:0] xfer_cnt0;

  // Round-robin instance
  logic        rst1, in_valid1, s0_1, s1_1;
  logic        in_ready1;
  logic [7:0]  in_data1;
  logic [3:0]  out_valid1, out_ready1;
  logic [31:0] out_data1;
  logic [1:0]  rr_ptr1;
  logic [3:0]  xfer_cnt1;

  demux14_stream_router #(.WIDTH(8), .RR_MODE(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .s0(s0_0), .s1(s1_0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_data(out_data0), .rr_ptr(rr_ptr0),
    .xfer_cnt(xfer_cnt0)
  );

  demux14_stream_router #(.WIDTH(8), .RR_MODE(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .s0(s0_1), .s1(s1_1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .rr_ptr(rr_ptr1),
    .xfer_cnt(xfer_cnt1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive0(input logic v, input logic [7:0] d, input logic [1:0] ch);
    in_valid0 = v;
    in_data0  = d;
    s0_0      = ch[1];
    s1_0      = ch[0];
  endtask

  task automatic drive1(input logic v, input logic [7:0] d);
    in_valid1 = v;
    in_data1  = d;
    s0_1      = 1'($urandom_range(0, 1));
    s1_1      = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [7:0]  route_data [4];
    logic [3:0]  onehot;
    n_checks = 0;
    n_errors = 0;
    route_data[0] = 8'hA5;
    route_data[1] = 8'h3C;
    route_data[2] = 8'hF0;
    route_data[3] = 8'h0F;

    // Reset both instances for 2 cycles with in_valid held high
    rst0 = 1'b1; rst1 = 1'b1;
    drive0(1'b1, 8'h55, 2'b00); drive1(1'b1, 8'h55);
    out_ready0 = 4'b1111; out_ready1 = 4'b1111;
    tick(); tick();
    chk("rst_in_ready0", 32'(in_ready0), 32'h0);
    chk("rst_out_valid0", 32'(out_valid0), 32'h0);
    chk("rst_out_data0", out_data0, 32'h0);
    chk("rst_xfer0", 32'(xfer_cnt0), 32'h0);
    chk("rst_rr0", 32'(rr_ptr0), 32'h0);
    chk("rst_in_ready1", 32'(in_ready1), 32'h0);
    chk("rst_out_valid1", 32'(out_valid1), 32'h0);
    chk("rst_rr1", 32'(rr_ptr1), 32'h0);
    chk("rst_xfer1", 32'(xfer_cnt1), 32'h0);

    // Directed route, one word per channel on consecutive cycles
    rst0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, route_data[i], 2'(i));
      settle();
      chk("route_in_ready", 32'(in_ready0), 32'h1);
      tick();
      onehot = 4'b0001 << i;
      chk("route_valid", 32'(out_valid0), 32'(onehot));
      chk("route_data", 32'(out_data0[i*8 +: 8]), 32'(route_data[i]));
    end
    chk("route_data_ch3_only", out_data0, 32'h0F00_0000);
    chk("route_xfer", 32'(xfer_cnt0), 32'd4);
    drive0(1'b0, 8'h00, 2'b00);
    tick();
    chk("route_drained", 32'(out_valid0), 32'h0);

    // Back-pressure on channel 2
    out_ready0 = 4'b1011;
    drive0(1'b1, 8'h11, 2'b10);
    settle();
    chk("bp_first_ready", 32'(in_ready0), 32'h1);
    tick();
    drive0(1'b1, 8'h22, 2'b10);
    settle();
    chk("bp_second_blocked", 32'(in_ready0), 32'h0);
    tick();
    chk("bp_hold_data", 32'(out_data0[23:16]), 32'h11);
    chk("bp_hold_valid", 32'(out_valid0), 32'b0100);
    drive0(1'b1, 8'h33, 2'b01);
    settle();
    chk("bp_ch1_ready", 32'(in_ready0), 32'h1);
    tick();
    chk("bp_ch1_valid", 32'(out_valid0), 32'b0110);
    chk("bp_ch1_data", 32'(out_data0[15:8]), 32'h33);
    chk("bp_ch2_still", 32'(out_data0[23:16]), 32'h11);
    drive0(1'b1, 8'h22, 2'b10);
    out_ready0 = 4'b1111;
    settle();
    chk("bp_passthru_ready", 32'(in_ready0), 32'h1);
    tick();
    chk("bp_passthru_data", 32'(out_data0[23:16]), 32'h22);
    chk("bp_passthru_valid", 32'(out_valid0), 32'b0100);
    chk("bp_xfer", 32'(xfer_cnt0), 32'd7);
    drive0(1'b0, 8'h00, 2'b00);
    tick();
    chk("bp_drained", 32'(out_valid0), 32'h0);

    // Round-robin: words 1..6 land on channels 0,1,2,3,0,1
    rst1 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drive1(1'b1, 8'(i));
      tick();
      onehot = 4'b0001 << ((i - 1) % 4);
      chk("rr_valid", 32'(out_valid1), 32'(onehot));
      chk("rr_data", 32'(out_data1[((i - 1) % 4)*8 +: 8]), 32'(i));
    end
    drive1(1'b0, 8'h00);
    settle();
    chk("rr_ptr_after6", 32'(rr_ptr1), 32'd2);
    chk("rr_xfer6", 32'(xfer_cnt1), 32'd6);
    tick();

    // Round-robin stall: words 7..13 with channel 1 blocked
    out_ready1 = 4'b1101;
    for (int i = 7; i <= 13; i++) begin
      drive1(1'b1, 8'(i));
      tick();
    end
    settle();
    chk("rrs_ptr", 32'(rr_ptr1), 32'd1);
    chk("rrs_blocked", 32'(in_ready1), 32'h0);
    drive1(1'b1, 8'd14);
    tick(); tick();
    chk("rrs_ptr_hold", 32'(rr_ptr1), 32'd1);
    chk("rrs_still_blocked", 32'(in_ready1), 32'h0);
    chk("rrs_ch1_data", 32'(out_data1[15:8]), 32'd10);
    out_ready1 = 4'b1111;
    settle();
    chk("rrs_unblocked", 32'(in_ready1), 32'h1);
    tick();
    chk("rrs_ch1_new", 32'(out_data1[15:8]), 32'd14);
    chk("rrs_ptr_adv", 32'(rr_ptr1), 32'd2);
    chk("rrs_xfer14", 32'(xfer_cnt1), 32'd14);

    // Fill all four slots; transfer 17 wraps the 4-bit counter to 1
    out_ready1 = 4'b0000;
    for (int i = 15; i <= 17; i++) begin
      drive1(1'b1, 8'(i));
      tick();
    end
    chk("full_valid", 32'(out_valid1), 32'hF);
    chk("full_data", out_data1, {8'd16, 8'd15, 8'd14, 8'd17});
    chk("wrap_xfer", 32'(xfer_cnt1), 32'd1);

    // Mid-operation reset discards everything
    rst1 = 1'b1;
    out_ready1 = 4'b1111;
    drive1(1'b1, 8'd18);
    settle();
    chk("mrst_in_ready", 32'(in_ready1), 32'h0);
    tick();
    chk("mrst_valid", 32'(out_valid1), 32'h0);
    chk("mrst_data", out_data1, 32'h0);
    chk("mrst_xfer", 32'(xfer_cnt1), 32'h0);
    chk("mrst_rr", 32'(rr_ptr1), 32'h0);
    rst1 = 1'b0;
    drive1(1'b0, 8'd0);
    tick();
    chk("mrst_lost", 32'(out_valid1), 32'h0);
    chk("mrst_xfer_idle", 32'(xfer_cnt1), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/demux14_stream_router.md
Name: demux14_stream_router

Overview:
Registered, flow-controlled version of the 1:4 demultiplexer. It accepts a valid/ready input stream and routes each word to one of four output channels. Each output channel has a one-entry holding register with its own valid/ready handshake, so a stalled consumer blocks only its own channel. It sits between a single producer and four independent consumers, and replaces the combinational 1:4 demux wherever consumers can back-pressure.

Parameters:
- WIDTH, 8, data word width in bits.
- RR_MODE, 0, channel selection. 0 = channel taken from {s0,s1}; 1 = internal round-robin pointer, with s0/s1 ignored.
- CNT_W, 16, width of the accepted-transfer counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  producer has a word.
- in_ready  out  1  router accepts the word this cycle.
- in_data  in  WIDTH  input word.
- s0  in  1  select MSB. Channel index = {s0,s1}, so s0=1,s1=0 selects channel 2.
- s1  in  1  select LSB.
- out_valid  out  4  bit c = channel c holds a word.
- out_ready  in  4  bit c = consumer c takes the word this cycle.
- out_data  out  4*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- rr_ptr  out  2  current round-robin target (always 0 when RR_MODE=0).
- xfer_cnt  out  CNT_W  count of accepted input transfers.

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0, all holding registers=0, rr_ptr=0, xfer_cnt=0.
  - in_ready is forced 0 while rst=1.
  - A reset mid-operation discards any held words; no output handshake completes in that cycle.
- Target channel: ch = {s0,s1} when RR_MODE=0, else ch = rr_ptr. ch is sampled only in the accept cycle; s0/s1 may change freely at other times.
- Ready rule: in_ready = !rst && (!out_valid[ch] || out_ready[ch]). The router accepts into an empty slot, or into a full slot that is draining in the same cycle (pass-through, no bubble).
- Accept: when in_valid && in_ready at an edge:
  - slot[ch] <= in_data and out_valid[ch] <= 1.
  - xfer_cnt increments, wrapping from 2^CNT_W-1 to 0.
  - In RR_MODE=1, rr_ptr increments mod 4 (3 -> 0).
- Latency: a word accepted at edge k is visible on out_data/out_valid[ch] after edge k (1 cycle).
- Drain: for any channel c, out_valid[c] && out_ready[c] at an edge clears out_valid[c], unless a new word is accepted into c at the same edge, in which case out_valid stays 1 with the new data.
- Hold: while out_valid[c]=1 and out_ready[c]=0, out_data for channel c is stable.
- Gating: out_data for channel c reads 0 whenever out_valid[c]=0, matching combinational demux semantics for unselected outputs.
- Channels are independent. Draining or stalling one channel never alters another channel's valid or data.
- In RR_MODE=1, rr_ptr does not skip a blocked channel; the input stalls until that channel frees (strict order).
- If in_valid=0, or the target slot is full and not draining, the router accepts nothing and changes no state except drains.

Decomposition:
- Shared package demux14_pkg:
  - NUM_CH=4, CH_W=2.
  - Channel index typedef ch_idx_t (2 bits).
  - Constants CH0..CH3 = 2'b00..2'b11, with {s0,s1} ordering documented.
- Sub-module demux14_slot, instantiated 4x: one-entry register.
  - Inputs: clk, rst, load, load_data, drain.
  - Outputs: valid, data (0-gated).
  - Top level: ready derivation, ch mux, rr_ptr, xfer_cnt.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=4'b0000, out_data=0, xfer_cnt=0, rr_ptr=0.
- Directed route, RR_MODE=0: out_ready=4'b1111; send 8'hA5 with {s0,s1}=00, 8'h3C with 01, 8'hF0 with 10, 8'h0F with 11 on consecutive cycles -> each appears 1 cycle later on channels 0..3 respectively, one out_valid bit per cycle, xfer_cnt=4.
- Back-pressure:
  - out_ready[2]=0; send 8'h11 then 8'h22 to channel 2 -> first accepted, in_ready=0 for the second, out_data ch2 held at 8'h11.
  - Concurrently send 8'h33 to channel 1 -> accepted.
  - Raise out_ready[2] -> 8'h22 accepted in the same cycle (pass-through), ch2 shows 8'h22 next cycle.
- Round-robin, RR_MODE=1: out_ready=4'b1111; send 6 words 1..6 with random s0/s1 -> they land on channels 0,1,2,3,0,1; rr_ptr=2 afterwards.
- Round-robin stall, RR_MODE=1: out_ready[1]=0 with ch1 full -> rr_ptr stays 1 and in_ready=0 until out_ready[1]=1.
- Mid-operation reset and wrap:
  - All 4 slots full, assert rst for 1 cycle -> out_valid=0 next cycle and held words are lost.
  - CNT_W=4: run 17 transfers -> xfer_cnt=1.
